// File: rtl/iir_out_round_sat_pkg.sv
// Shared iir8 constants plus a reference round/saturate helper for model reuse.
package iir_out_round_sat_pkg;

    localparam int unsigned IIR_NSAMP      = 8;
    localparam int unsigned IIR_MACC_BITS  = 27;
    localparam int unsigned IIR_MACC_FRAC  = 13;
    localparam int unsigned IIR_SAMP_BITS  = 12;
    localparam int unsigned IIR_ROUND_BITS = IIR_MACC_BITS + 1 - IIR_MACC_FRAC;

    typedef struct packed {
        logic                     sat;
        logic [IIR_SAMP_BITS-1:0] out;
    } sat_round_t;

    // Round half up to integer, then clamp to the signed sample range.
    function automatic sat_round_t sat_round(input logic [IIR_MACC_BITS-1:0] din);
        logic [IIR_MACC_BITS:0]    sum;
        logic [IIR_ROUND_BITS-1:0] r;
        logic [IIR_ROUND_BITS-IIR_SAMP_BITS:0] upper;
        sat_round_t res;
        sum   = {din[IIR_MACC_BITS-1], din} + ((IIR_MACC_BITS+1)'(1) << (IIR_MACC_FRAC - 1));
        r     = sum[IIR_MACC_BITS:IIR_MACC_FRAC];
        upper = r[IIR_ROUND_BITS-1:IIR_SAMP_BITS-1];
        if (upper == '0 || upper == '1) begin
            res.sat = 1'b0;
            res.out = r[IIR_SAMP_BITS-1:0];
        end else begin
            res.sat = 1'b1;
            res.out = r[IIR_ROUND_BITS-1] ? {1'b1, {(IIR_SAMP_BITS-1){1'b0}}}
                                          : {1'b0, {(IIR_SAMP_BITS-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_out_round_sat_lane.sv
// One lane: stage 1 rounds half up, stage 2 saturates to OUT_BITS signed.
module iir_round_sat_lane
    import iir_out_round_sat_pkg::*;
#(
    parameter int unsigned IN_BITS   = IIR_MACC_BITS,
    parameter int unsigned FRAC_BITS = IIR_MACC_FRAC,
    parameter int unsigned OUT_BITS  = IIR_SAMP_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_BITS-1:0]  din,
    output logic [OUT_BITS-1:0] dout,
    output logic                sat,
    output logic                sat_next
);

    localparam int unsigned R_BITS = IN_BITS + 1 - FRAC_BITS;
    localparam logic [IN_BITS:0] HALF =
        {{(IN_BITS + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

    logic [IN_BITS:0]         sum;
    logic [R_BITS-1:0]        r_q;
    logic [R_BITS-OUT_BITS:0] upper;
    logic [OUT_BITS-1:0]      dout_next;

    always_comb begin
        sum = {din[IN_BITS-1], din} + HALF;
    end

    // In range exactly when every bit above the output sign bit matches it.
    always_comb begin
        upper     = r_q[R_BITS-1:OUT_BITS-1];
        sat_next  = 1'b0;
        dout_next = r_q[OUT_BITS-1:0];
        if (!(upper == '0 || upper == '1)) begin
            sat_next  = 1'b1;
            dout_next = r_q[R_BITS-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                      : {1'b0, {(OUT_BITS-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            dout <= '0;
            sat  <= 1'b0;
        end else begin
            r_q  <= sum[IN_BITS:FRAC_BITS];
            dout <= dout_next;
            sat  <= sat_next;
        end
    end

endmodule

// File: rtl/iir_out_round_sat.sv
// iir8 output stage: per-lane round + saturate, valid pipeline and saturation statistics.
module iir_out_round_sat
    import iir_out_round_sat_pkg::*;
#(
    parameter int unsigned NSAMP     = IIR_NSAMP,
    parameter int unsigned IN_BITS   = IIR_MACC_BITS,
    parameter int unsigned FRAC_BITS = IIR_MACC_FRAC,
    parameter int unsigned OUT_BITS  = IIR_SAMP_BITS,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NSAMP*IN_BITS-1:0]  dat_i,
    input  logic                      valid_i,
    output logic [NSAMP*OUT_BITS-1:0] dat_o,
    output logic                      valid_o,
    output logic [NSAMP-1:0]          sat_o,
    output logic                      sat_flag_o,
    output logic [CNT_BITS-1:0]       sat_cnt_o,
    input  logic                      sat_clr_i
);

    logic [NSAMP-1:0] lane_sat;
    logic [NSAMP-1:0] lane_sat_next;
    logic             valid_s1;
    logic             sat_event;

    for (genvar k = 0; k < NSAMP; k++) begin : g_lane
        iir_round_sat_lane #(
            .IN_BITS   (IN_BITS),
            .FRAC_BITS (FRAC_BITS),
            .OUT_BITS  (OUT_BITS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (dat_i[k*IN_BITS +: IN_BITS]),
            .dout     (dat_o[k*OUT_BITS +: OUT_BITS]),
            .sat      (lane_sat[k]),
            .sat_next (lane_sat_next[k])
        );
    end

    always_comb begin
        sat_o = lane_sat & {NSAMP{valid_o}};
    end

    // Event is taken from the stage-2 inputs so the stats move on the same edge as sat_o.
    always_comb begin
        sat_event = valid_s1 && (|lane_sat_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1 <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            valid_s1 <= valid_i;
            valid_o  <= valid_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_o <= 1'b0;
            sat_cnt_o  <= '0;
        end else if (sat_clr_i) begin
            sat_flag_o <= sat_event;
            sat_cnt_o  <= sat_event ? CNT_BITS'(1) : '0;
        end else if (sat_event) begin
            sat_flag_o <= 1'b1;
            if (sat_cnt_o != '1) begin
                sat_cnt_o <= sat_cnt_o + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_iir_out_round_sat.sv
// Scoreboard bench for iir_out_round_sat: directed rounding/saturation/stats cases plus random beats.
module tb_iir_out_round_sat;

    localparam int NS = 8;
    localparam int IB = 27;
    localparam int OB = 12;
    localparam int CB = 16;
    localparam int DW = NS * IB;
    localparam int OW = NS * OB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] dat_i;
    logic          valid_i;
    logic [OW-1:0] dat_o;
    logic          valid_o;
    logic [NS-1:0] sat_o;
    logic          sat_flag_o;
    logic [CB-1:0] sat_cnt_o;
    logic          sat_clr_i;

    iir_out_round_sat #(
        .NSAMP     (NS),
        .IN_BITS   (IB),
        .FRAC_BITS (13),
        .OUT_BITS  (OB),
        .CNT_BITS  (CB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dat_i      (dat_i),
        .valid_i    (valid_i),
        .dat_o      (dat_o),
        .valid_o    (valid_o),
        .sat_o      (sat_o),
        .sat_flag_o (sat_flag_o),
        .sat_cnt_o  (sat_cnt_o),
        .sat_clr_i  (sat_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [OW-1:0] d;
        logic [NS-1:0] s;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        mon_en = 1'b0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Floor division formulation of round-half-up, then clamp.
    function automatic logic [OB:0] ref_lane(input logic [IB-1:0] x);
        longint v;
        longint q;
        v = longint'($signed(x)) + 64'sd4096;
        q = v / 64'sd8192;
        if (v < 0 && (v % 64'sd8192) != 0) q = q - 1;
        if (q > 2047)  return {1'b1, 12'h7FF};
        if (q < -2048) return {1'b1, 12'h800};
        return {1'b0, q[11:0]};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_o", 256'(valid_o), 256'(1));
                chk("dat_o",   256'(dat_o),   256'(e.d));
                chk("sat_o",   256'(sat_o),   256'(e.s));
            end else begin
                chk("valid_o_idle", 256'(valid_o), 256'(0));
                chk("sat_o_idle",   256'(sat_o),   256'(0));
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the beat captured.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic clr,
                         input logic [OW-1:0] ed, input logic [NS-1:0] es);
        exp_t e;
        valid_i   = v;
        dat_i     = d;
        sat_clr_i = clr;
        if (v) begin
            e.due = cyc + 2;
            e.d   = ed;
            e.s   = es;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive_model(input logic v, input logic [DW-1:0] d, input logic clr);
        logic [OW-1:0] ed;
        logic [NS-1:0] es;
        logic [OB:0]   r;
        for (int k = 0; k < NS; k++) begin
            r = ref_lane(d[k*IB +: IB]);
            ed[k*OB +: OB] = r[OB-1:0];
            es[k] = r[OB];
        end
        drive(v, d, clr, ed, es);
    endtask

    task automatic idle(input logic clr);
        drive(1'b0, '0, clr, '0, '0);
    endtask

    task automatic one_lane(input int lane, input logic [IB-1:0] x,
                            input logic [OB-1:0] eo, input logic es);
        logic [DW-1:0] d;
        logic [OW-1:0] ed;
        logic [NS-1:0] s;
        d = '0;
        ed = '0;
        s = '0;
        d[lane*IB +: IB]  = x;
        ed[lane*OB +: OB] = eo;
        s[lane] = es;
        drive(1'b1, d, 1'b0, ed, s);
    endtask

    task automatic chk_stats(input string tag, input logic f, input logic [CB-1:0] c);
        chk({tag, "_flag"}, 256'(sat_flag_o), 256'(f));
        chk({tag, "_cnt"},  256'(sat_cnt_o),  256'(c));
    endtask

    logic [DW-1:0] all_max;
    logic [OW-1:0] all_pos;
    logic [IB-1:0] edge_vals [6];

    initial begin
        all_max = '0;
        all_pos = '0;
        for (int k = 0; k < NS; k++) begin
            all_max[k*IB +: IB] = 27'h3FF_FFFF;
            all_pos[k*OB +: OB] = 12'h7FF;
        end
        edge_vals[0] = 27'(16773119);   // just below +2047.5
        edge_vals[1] = 27'(16773120);   // +2047.5
        edge_vals[2] = 27'(-16781312);  // -2048.5 rounds to -2048
        edge_vals[3] = 27'(-16781313);
        edge_vals[4] = 27'h400_0000;
        edge_vals[5] = 27'h3FF_FFFF;

        rst_n = 1'b0;
        dat_i = '0;
        valid_i = 1'b0;
        sat_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dat_o",   256'(dat_o),   256'(0));
        chk("rst_valid_o", 256'(valid_o), 256'(0));
        chk("rst_sat_o",   256'(sat_o),   256'(0));
        chk_stats("rst", 1'b0, '0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // rounding on lane 0
        one_lane(0, 27'h000_1000, 12'd1,     1'b0);
        one_lane(0, 27'h000_0FFF, 12'd0,     1'b0);
        one_lane(0, 27'h7FF_F000, 12'd0,     1'b0);
        one_lane(0, 27'h7FF_D000, 12'hFFF,   1'b0);
        idle(1'b0);
        idle(1'b0);
        chk_stats("round", 1'b0, '0);

        // saturation high/low
        one_lane(3, 27'(16773120),  12'h7FF, 1'b1);
        one_lane(5, 27'(-16782131), 12'h800, 1'b1);
        idle(1'b0);
        chk_stats("sat2", 1'b1, 16'd2);
        idle(1'b1);
        chk_stats("clr", 1'b0, '0);
        one_lane(7, 27'h3FF_FFFF, 12'h7FF, 1'b1);
        idle(1'b0);
        chk_stats("lane7", 1'b1, 16'd1);

        // counter saturation
        idle(1'b1);
        for (int i = 0; i < 66000; i++) drive(1'b1, all_max, 1'b0, all_pos, '1);
        idle(1'b0);
        chk_stats("cnt_hold", 1'b1, 16'hFFFF);
        for (int i = 0; i < 5; i++) drive(1'b0, all_max, 1'b0, '0, '0);
        idle(1'b0);
        idle(1'b0);
        chk_stats("invalid_nocount", 1'b1, 16'hFFFF);

        // clear coinciding with an event, then clear alone
        drive(1'b1, all_max, 1'b0, all_pos, '1);
        idle(1'b1);
        chk_stats("clr_race", 1'b1, 16'd1);
        idle(1'b1);
        chk_stats("clr_alone", 1'b0, '0);

        // reset with beats in flight
        drive(1'b1, all_max, 1'b0, all_pos, '1);
        idle(1'b0);
        chk_stats("pre_rst", 1'b1, 16'd1);
        drive_model(1'b1, all_max, 1'b0);
        valid_i = 1'b1;
        dat_i = all_max;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        valid_i = 1'b0;
        dat_i = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_stats("mid_rst", 1'b0, '0);
        idle(1'b0);
        chk("post_rst_v1", 256'(valid_o), 256'(0));
        idle(1'b0);
        chk("post_rst_v2", 256'(valid_o), 256'(0));
        chk_stats("post_rst", 1'b0, '0);

        // random regression
        for (int i = 0; i < 10000; i++) begin
            logic [DW-1:0] d;
            for (int k = 0; k < NS; k++) begin
                case ($urandom_range(0, 3))
                    0: d[k*IB +: IB] = 27'($urandom);
                    1: d[k*IB +: IB] = edge_vals[$urandom_range(0, 5)];
                    default: d[k*IB +: IB] = 27'($signed($urandom_range(0, 33554432)) - 33'sd16777216);
                endcase
            end
            drive_model($urandom_range(0, 4) != 0, d, 1'b0);
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("sb_drained", 256'(sb.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
